// File: rtl/gray_cnt_pkg.sv
// rtl/gray_cnt_pkg.sv - shared constants and Gray conversion for the multi-digit Gray counter
package gray_cnt_pkg;

  localparam int DIGITS_MIN  = 1;
  localparam int DIGITS_MAX  = 8;
  localparam int DIGIT_W_MIN = 2;
  localparam int DIGIT_W_MAX = 6;
  localparam int DIGIT_MOD_MIN = 2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Reflected Gray code of the low 'width' bits of value; upper bits are forced to zero.
  function automatic logic [7:0] bin2gray(input logic [7:0] value, input int width);
    logic [7:0] mask;
    mask = 8'((9'd1 << width) - 9'd1);
    return (value ^ (value >> 1)) & mask;
  endfunction

endpackage

// File: rtl/gray_cnt_digit.sv
// rtl/gray_cnt_digit.sv - one modulo-DIGIT_MOD up/down digit with registered binary and Gray outputs
module gray_cnt_digit
  import gray_cnt_pkg::*;
#(
  parameter int DIGIT_W   = 4,
  parameter int DIGIT_MOD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               dir,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] bin,
  output logic [DIGIT_W-1:0] gray,
  output logic               at_max,
  output logic               at_min
);

  localparam logic [DIGIT_W-1:0] TERM = DIGIT_W'(DIGIT_MOD - 1);

  logic [DIGIT_W-1:0] bin_next;
  logic [DIGIT_W-1:0] gray_next;

  assign at_max = (bin == TERM);
  assign at_min = (bin == '0);

  always_comb begin
    bin_next = bin;
    if (clr) begin
      bin_next = '0;
    end else if (load) begin
      bin_next = (load_val > TERM) ? TERM : load_val;
    end else if (step) begin
      if (dir == DIR_UP) begin
        bin_next = at_max ? '0 : bin + 1'b1;
      end else begin
        bin_next = at_min ? TERM : bin - 1'b1;
      end
    end
  end

  // Gray is derived from the next binary value so both outputs move on the same edge.
  assign gray_next = DIGIT_W'(bin2gray(8'(bin_next), DIGIT_W));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/gray_multi_counter.sv
// rtl/gray_multi_counter.sv - N-digit up/down counter with per-digit Gray outputs, wrap or saturate
module gray_multi_counter
  import gray_cnt_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int DIGIT_MOD = 16,
  parameter int SATURATE  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       clr,
  input  logic                       load,
  input  logic [DIGITS*DIGIT_W-1:0]  load_val,
  output logic [DIGITS*DIGIT_W-1:0]  gray,
  output logic [DIGITS*DIGIT_W-1:0]  bin,
  output logic                       cout,
  output logic                       wrapped,
  output logic                       sat
);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $fatal(1, "gray_multi_counter: DIGITS out of range");
  end
  if (DIGIT_W < DIGIT_W_MIN || DIGIT_W > DIGIT_W_MAX) begin : g_bad_width
    $fatal(1, "gray_multi_counter: DIGIT_W out of range");
  end
  if (DIGIT_MOD < DIGIT_MOD_MIN || DIGIT_MOD > (1 << DIGIT_W)) begin : g_bad_mod
    $fatal(1, "gray_multi_counter: DIGIT_MOD out of range");
  end

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic              term_up;
  logic              term_dn;
  logic              hold;

  assign term_up = &at_max;
  assign term_dn = &at_min;
  assign cout    = en & ~clr & ~load & ((dir == DIR_UP) ? term_up : term_dn);
  assign hold    = (SATURATE != 0) & cout;
  assign sat     = hold;

  // Ripple enable: a digit steps only when every lower digit sits at its extreme.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign step[i] = en & ~hold;
    end else begin : g_rest
      assign step[i] = step[i-1] & ((dir == DIR_UP) ? at_max[i-1] : at_min[i-1]);
    end

    gray_cnt_digit #(
      .DIGIT_W   (DIGIT_W),
      .DIGIT_MOD (DIGIT_MOD)
    ) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step[i]),
      .dir      (dir),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[i*DIGIT_W +: DIGIT_W]),
      .bin      (bin[i*DIGIT_W +: DIGIT_W]),
      .gray     (gray[i*DIGIT_W +: DIGIT_W]),
      .at_max   (at_max[i]),
      .at_min   (at_min[i])
    );
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= (SATURATE == 0) && cout;
    end
  end

endmodule

// File: tb/tb_gray_multi_counter.sv
// tb/tb_gray_multi_counter.sv - self-checking bench over four parameter corners with a mixed-radix model
module tb_gray_multi_counter;

  localparam int N = 4;
  localparam int CD [N] = '{4, 2, 4, 3};
  localparam int CW [N] = '{4, 4, 4, 3};
  localparam int CM [N] = '{16, 10, 16, 5};
  localparam int CS [N] = '{0, 0, 1, 1};
  localparam int GTAB [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  logic clk = 1'b0;
  logic rst_n, en, dir, clr, load;
  logic [31:0] lvk [N];
  logic [15:0] bin0, gray0, bin2, gray2;
  logic [7:0]  bin1, gray1;
  logic [8:0]  bin3, gray3;
  logic [N-1:0] cout, wrapped, sat;
  logic [31:0] obin [N];
  logic [31:0] ogray [N];

  int total = 0;
  int bad = 0;
  int mval [N];
  bit mwr [N];

  always #5 clk = ~clk;

  gray_multi_counter #(.DIGITS(4), .DIGIT_W(4), .DIGIT_MOD(16), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lvk[0][15:0]), .gray(gray0), .bin(bin0),
    .cout(cout[0]), .wrapped(wrapped[0]), .sat(sat[0]));
  gray_multi_counter #(.DIGITS(2), .DIGIT_W(4), .DIGIT_MOD(10), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lvk[1][7:0]), .gray(gray1), .bin(bin1),
    .cout(cout[1]), .wrapped(wrapped[1]), .sat(sat[1]));
  gray_multi_counter #(.DIGITS(4), .DIGIT_W(4), .DIGIT_MOD(16), .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lvk[2][15:0]), .gray(gray2), .bin(bin2),
    .cout(cout[2]), .wrapped(wrapped[2]), .sat(sat[2]));
  gray_multi_counter #(.DIGITS(3), .DIGIT_W(3), .DIGIT_MOD(5), .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(lvk[3][8:0]), .gray(gray3), .bin(bin3),
    .cout(cout[3]), .wrapped(wrapped[3]), .sat(sat[3]));

  assign obin[0] = {16'b0, bin0};
  assign obin[1] = {24'b0, bin1};
  assign obin[2] = {16'b0, bin2};
  assign obin[3] = {23'b0, bin3};
  assign ogray[0] = {16'b0, gray0};
  assign ogray[1] = {24'b0, gray1};
  assign ogray[2] = {16'b0, gray2};
  assign ogray[3] = {23'b0, gray3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mmax(input int k);
    int p = 1;
    for (int i = 0; i < CD[k]; i++) p = p * CM[k];
    return p - 1;
  endfunction

  // Spread a mixed-radix value into per-digit fields, optionally Gray coded.
  function automatic logic [31:0] pack(input int k, input int v, input bit as_gray);
    logic [31:0] r = 0;
    int d;
    for (int i = 0; i < CD[k]; i++) begin
      d = v % CM[k];
      v = v / CM[k];
      if (as_gray) d = d ^ (d >> 1);
      r = r | (32'(d) << (i * CW[k]));
    end
    return r;
  endfunction

  function automatic int unpack_clamped(input int k, input logic [31:0] raw);
    int v = 0;
    int d;
    for (int i = CD[k] - 1; i >= 0; i--) begin
      d = int'((raw >> (i * CW[k])) & ((32'd1 << CW[k]) - 1));
      if (d > CM[k] - 1) d = CM[k] - 1;
      v = v * CM[k] + d;
    end
    return v;
  endfunction

  function automatic bit mcout(input int k);
    return en && !clr && !load && (dir ? (mval[k] == mmax(k)) : (mval[k] == 0));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mval[k] = 0;
      mwr[k] = 0;
    end
  endtask

  // Starts at a rising edge with inputs already driven, ends at the next rising edge.
  task automatic tick();
    bit c [N];
    #1;
    for (int k = 0; k < N; k++) begin
      c[k] = mcout(k);
      check($sformatf("cout%0d", k), 32'(cout[k]), 32'(c[k]));
      check($sformatf("sat%0d", k), 32'(sat[k]), 32'((CS[k] != 0) && c[k]));
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      mwr[k] = 0;
      if (!rst_n) mval[k] = 0;
      else if (clr) mval[k] = 0;
      else if (load) mval[k] = unpack_clamped(k, lvk[k]);
      else if (en) begin
        if (c[k]) begin
          if (CS[k] == 0) begin
            mval[k] = dir ? 0 : mmax(k);
            mwr[k] = 1;
          end
        end else begin
          mval[k] = dir ? mval[k] + 1 : mval[k] - 1;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("bin%0d", k), obin[k], pack(k, mval[k], 1'b0));
      check($sformatf("gray%0d", k), ogray[k], pack(k, mval[k], 1'b1));
      check($sformatf("wrapped%0d", k), 32'(wrapped[k]), 32'(mwr[k]));
    end
  endtask

  initial begin
    rst_n = 0; en = 0; dir = 1; clr = 0; load = 0;
    for (int k = 0; k < N; k++) lvk[k] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check("reset_bin", obin[k], 32'h0);
      check("reset_gray", ogray[k], 32'h0);
      check("reset_wrapped", 32'(wrapped[k]), 32'h0);
    end
    @(posedge clk);
    rst_n = 1;

    // Up count from zero: digit0 Gray sequence and digit1 cadence.
    en = 1; dir = 1;
    for (int n = 1; n <= 256; n++) begin
      tick();
      check("gray_d0_seq", 32'(gray0[3:0]), 32'(GTAB[n % 16]));
      check("gray_d1_seq", 32'(gray0[7:4]), 32'(GTAB[(n / 16) % 16]));
    end

    // Terminal count on the full 16-bit counter.
    en = 0; load = 1; lvk[0] = 32'hFFFE;
    tick();
    load = 0; en = 1; dir = 1;
    tick();
    check("u0_at_ffff", obin[0], 32'hFFFF);
    #1 check("u0_cout_ffff", 32'(cout[0]), 32'h1);
    tick();
    check("u0_wrap_zero", obin[0], 32'h0);
    check("u0_wrap_pulse", 32'(wrapped[0]), 32'h1);

    // Decimal digits: load 99 then wrap, then clamp of out-of-range digits.
    en = 0; load = 1; lvk[1] = 32'h99;
    tick();
    load = 0; en = 1; dir = 1;
    tick();
    check("u1_99_wrap", obin[1], 32'h00);
    check("u1_99_pulse", 32'(wrapped[1]), 32'h1);
    en = 0; load = 1; lvk[1] = 32'hFC;
    tick();
    check("u1_clamp", obin[1], 32'h99);
    load = 0;

    // Down from zero: wrap on u0, saturate on u2, then leave saturation.
    clr = 1;
    tick();
    clr = 0; en = 1; dir = 0;
    #1 check("u0_cout_down", 32'(cout[0]), 32'h1);
    tick();
    check("u0_down_wrap", obin[0], 32'hFFFF);
    check("u0_down_pulse", 32'(wrapped[0]), 32'h1);
    check("u2_sat_hold", obin[2], 32'h0);
    #1 check("u2_sat_flag", 32'(sat[2]), 32'h1);
    dir = 1;
    tick();
    check("u2_sat_leave", obin[2], 32'h1);

    // Priority clr > load > en.
    clr = 1; load = 1; en = 1; lvk[0] = 32'h5555;
    tick();
    check("prio_clr", obin[0], 32'h0);
    clr = 0; lvk[0] = 32'h4321;
    tick();
    check("prio_load", obin[0], 32'h4321);

    // Asynchronous reset between edges.
    lvk[0] = 32'h1234;
    tick();
    load = 0; en = 1; dir = 1;
    #2 rst_n = 0;
    #1;
    check("async_bin", obin[0], 32'h0);
    check("async_gray", ogray[0], 32'h0);
    model_reset();
    @(negedge clk);
    #1 check("async_no_count", obin[0], 32'h0);
    @(posedge clk);
    rst_n = 1;
    tick();
    check("post_reset_count", obin[0], 32'h1);

    // Randomized control against the model.
    for (int n = 0; n < 10000; n++) begin
      clr  = ($urandom_range(0, 99) < 4);
      load = ($urandom_range(0, 99) < 5);
      en   = ($urandom_range(0, 99) < 85);
      dir  = ($urandom_range(0, 99) < 55);
      for (int k = 0; k < N; k++) lvk[k] = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
